// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants and types for the seven-segment scan driver
// Purpose: hex segment table (active-low, {g,f,e,d,c,b,a}), blanking constants,
//          and the scan FSM state type.
// Ports:   none (package).
package seg7_pkg;

    localparam logic [3:0] ANODES_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF    = 7'h7F;

    // Entry n is the pattern for hex digit n; entry 15 is written first.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - load/ack handshake between upstream logic and the scan driver
// Purpose: carries a new 16-bit display value and its load request; the driver
//          answers with a one-cycle load_ack once the value is committed.
// Signals: value[15:0], load (upstream -> driver), load_ack (driver -> upstream).
// Modports: master = upstream producer, slave = scan driver.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic        load;
    logic        load_ack;

    modport master (output value, output load, input  load_ack);
    modport slave  (input  value, input  load, output load_ack);
endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decoder
// Purpose: looks up the segment pattern of a 4-bit value.
// Ports:   i_hex[3:0] nibble in; o_seg[6:0] segments {g..a}, active-low.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    assign o_seg = HEX_SEG_TABLE[i_hex];
endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit seven-segment scan controller with frame-synchronous value load
// Purpose: prescaled digit scan with inter-digit blanking, registered segment
//          decode, and a load/ack handshake that only commits at the 3->0 wrap.
// Ports:   clk, rst (sync, active-high); enable (anodes on); ld (slave handshake:
//          value, load, load_ack); dp[3:0] per-digit decimal point;
//          disp_value[15:0] / dig_sel[1:0] to group_selector, selected_value[3:0]
//          back; seg_n[6:0], dp_n, an_n[3:0] active-low display drive.
// Option:  SEG7_LZ_BLANK_EN - leading-zero suppression on digits 3..1.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    seg7_scan_driver_if.slave    ld,
    input  logic [3:0]           dp,
    output logic [15:0]          disp_value,
    output logic [1:0]           dig_sel,
    input  logic [3:0]           selected_value,
    output logic [6:0]           seg_n,
    output logic                 dp_n,
    output logic [3:0]           an_n
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_blank_cnt, w_blank_cnt_nx;
    scan_state_t   r_state, w_state_nx;
    logic [1:0]    r_dig_sel;
    logic [15:0]   r_disp_value, r_pend_value;
    logic          r_pend, r_load_ack, r_dp_n;
    logic [6:0]    r_seg_n, w_seg;
    logic [3:0]    w_an_n;
    logic          w_tick, w_wrap, w_dark;

    assign w_tick = (r_presc == PRESC_LAST);
    assign w_wrap = w_tick && (r_dig_sel == 2'd3);

    hex_to_seg7 u_dec (
        .i_hex (selected_value),
        .o_seg (w_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    always_comb begin
        w_dark = 1'b0;
        case (r_dig_sel)
            2'd3:    w_dark = (r_disp_value[15:12] == 4'h0);
            2'd2:    w_dark = (r_disp_value[15:8]  == 8'h00);
            2'd1:    w_dark = (r_disp_value[15:4]  == 12'h000);
            default: w_dark = 1'b0;
        endcase
    end
`else
    assign w_dark = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_presc <= '0;
        else     r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= BLANK;
            r_blank_cnt <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_blank_cnt <= w_blank_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_blank_cnt_nx = r_blank_cnt;
        w_an_n         = ANODES_OFF;
        case (r_state)
            BLANK: begin
                if (r_blank_cnt == BLANK_LAST) begin
                    w_state_nx     = SHOW;
                    w_blank_cnt_nx = '0;
                end else begin
                    w_blank_cnt_nx = r_blank_cnt + 1'b1;
                end
            end
            SHOW: begin
                if (enable && !w_dark)
                    w_an_n = ~(4'b0001 << r_dig_sel);
            end
            default: w_state_nx = BLANK;
        endcase
        // Every digit change restarts the blanking window, whatever the state.
        if (w_tick) begin
            w_state_nx     = BLANK;
            w_blank_cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig_sel    <= 2'd0;
            r_seg_n      <= SEG_OFF;
            r_dp_n       <= 1'b1;
            r_disp_value <= 16'h0000;
            r_pend_value <= 16'h0000;
            r_pend       <= 1'b0;
            r_load_ack   <= 1'b0;
        end else begin
            r_seg_n    <= w_seg;
            r_dp_n     <= ~dp[r_dig_sel];
            r_load_ack <= 1'b0;
            if (w_tick)
                r_dig_sel <= r_dig_sel + 2'd1;
            // A load landing on the wrap tick skips the pending register.
            if (w_wrap && ld.load) begin
                r_disp_value <= ld.value;
                r_pend       <= 1'b0;
                r_load_ack   <= 1'b1;
            end else if (w_wrap && r_pend) begin
                r_disp_value <= r_pend_value;
                r_pend       <= 1'b0;
                r_load_ack   <= 1'b1;
            end else if (ld.load) begin
                r_pend_value <= ld.value;
                r_pend       <= 1'b1;
            end
        end
    end

    assign disp_value  = r_disp_value;
    assign dig_sel     = r_dig_sel;
    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign an_n        = w_an_n;
    assign ld.load_ack = r_load_ack;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  dp;
    logic [15:0] disp_value;
    logic [1:0]  dig_sel;
    logic [3:0]  selected_value;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        load_ack;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int ack_cnt = 0;
    int ack_base;
    logic [3:0] lit;
    logic [3:0] exp_an_first;
    logic [3:0] exp_lit;

    seg7_scan_driver_if ld_if ();

    seg7_scan_driver #(.TICK_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .ld             (ld_if),
        .dp             (dp),
        .disp_value     (disp_value),
        .dig_sel        (dig_sel),
        .selected_value (selected_value),
        .seg_n          (seg_n),
        .dp_n           (dp_n),
        .an_n           (an_n)
    );

    assign selected_value = disp_value[dig_sel*4 +: 4];
    assign load_ack       = ld_if.load_ack;

    always #5 clk = ~clk;

    always @(negedge clk) if (load_ack === 1'b1) ack_cnt <= ack_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
`ifdef SEG7_LZ_BLANK_EN
        exp_an_first = 4'hF;
        exp_lit      = 4'b0011;
`else
        exp_an_first = 4'b1101;
        exp_lit      = 4'b1111;
`endif
        rst = 1'b1; enable = 1'b1; dp = 4'h0;
        ld_if.load = 1'b0; ld_if.value = 16'h0000;
        step(); step();
        check("rst_an", an_n, 4'hF);
        check("rst_seg", seg_n, 7'h7F);
        check("rst_dp", dp_n, 1'b1);
        check("rst_dig", dig_sel, 2'd0);
        check("rst_disp", disp_value, 16'h0000);
        check("rst_ack", load_ack, 1'b0);
        rst = 1'b0; cyc = 0;

        // first tick is cycle 7; new digit at 8, segments at 9, anode at 10
        step_to(8);  check("tick_dig", dig_sel, 2'd1);
        step_to(9);  check("blank_an", an_n, 4'hF);
        check("blank_seg", seg_n, 7'h40);
        step_to(10); check("first_an", an_n, exp_an_first);

        step_to(20); ld_if.load = 1'b1; ld_if.value = 16'h1234;
        step_to(21); ld_if.load = 1'b0;
        check("pend_disp", disp_value, 16'h0000);
        check("pend_ack", load_ack, 1'b0);
        ack_base = ack_cnt;
        step_to(31); check("prewrap_disp", disp_value, 16'h0000);
        step_to(32); check("commit_disp", disp_value, 16'h1234);
        check("commit_ack", load_ack, 1'b1);
        check("wrap_dig", dig_sel, 2'd0);
        step_to(33); check("ack_drop", load_ack, 1'b0);
        check("seg_4", seg_n, 7'b0011001);
        step_to(34); check("dig0_an", an_n, 4'b1110);
        check("one_ack", ack_cnt - ack_base, 1);

        ack_base = ack_cnt;
        step_to(40); ld_if.load = 1'b1; ld_if.value = 16'hAAAA;
        step_to(41); ld_if.load = 1'b0;
        step_to(50); ld_if.load = 1'b1; ld_if.value = 16'h00F0;
        step_to(51); ld_if.load = 1'b0;
        step_to(63); check("last_hold", disp_value, 16'h1234);
        step_to(64); check("last_wins", disp_value, 16'h00F0);
        lit = 4'h0;
        while (cyc < 96) begin
            step();
            lit = lit | ~an_n;
        end
        check("lit_mask", lit, exp_lit);
        check("nopend_ack", load_ack, 1'b0);
        check("two_load_ack", ack_cnt - ack_base, 1);

        step_to(127); ld_if.load = 1'b1; ld_if.value = 16'hBEEF;
        step_to(128); ld_if.load = 1'b0;
        check("bypass_disp", disp_value, 16'hBEEF);
        check("bypass_ack", load_ack, 1'b1);
        step_to(129); check("bypass_drop", load_ack, 1'b0);

        step_to(130); dp = 4'b0001;
        step_to(131); check("dp_on", dp_n, 1'b0);
        check("seg_F", seg_n, 7'h0E);
        check("show_an", an_n, 4'b1110);
        enable = 1'b0; #1;
        check("disable_an", an_n, 4'hF);
        enable = 1'b1; dp = 4'h0;

        step_to(140); ld_if.load = 1'b1; ld_if.value = 16'h5555;
        step_to(141); ld_if.load = 1'b0; rst = 1'b1;
        step();
        check("mrst_an", an_n, 4'hF);
        check("mrst_seg", seg_n, 7'h7F);
        check("mrst_dp", dp_n, 1'b1);
        check("mrst_dig", dig_sel, 2'd0);
        check("mrst_disp", disp_value, 16'h0000);
        check("mrst_ack", load_ack, 1'b0);
        rst = 1'b0; cyc = 0;
        ack_base = ack_cnt;
        step_to(40);
        check("drop_disp", disp_value, 16'h0000);
        check("drop_ack", ack_cnt - ack_base, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed scan controller for the 4-digit seven-segment display. It owns the frame-stable display register and the 2-bit digit counter that drives `group_selector`'s `dig_sel`. It consumes the selected nibble back, decodes it to segments, and drives active-low anodes with an inter-digit blanking window to prevent ghosting. Upstream logic hands it new 16-bit values through a load/ack handshake; values are only committed at frame boundaries, so a frame never mixes old and new digits.

## Interface
Parameters:
- `TICK_DIV`, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 4..2^20.
- `BLANK_CYCLES`, 16: cycles with all anodes off after each digit change; legal range 1..TICK_DIV-2.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous reset, active-high.
- `enable`  in  1  display on; when low, anodes forced off and scanning continues.
- `value`  in  16  new display value (hex digits, digit 3 = [15:12]).
- `load`  in  1  request to display `value`.
- `load_ack`  out  1  one-cycle pulse when the pending value is committed to `disp_value`.
- `dp`  in  4  decimal point per digit, bit n = digit n, sampled live.
- `disp_value`  out  16  committed frame value, wired to `group_selector.value`.
- `dig_sel`  out  2  current digit index, wired to `group_selector.dig_sel`.
- `selected_value`  in  4  nibble returned by `group_selector`, combinational from `disp_value`/`dig_sel`.
- `seg_n`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp_n`  out  1  decimal point, active-low.
- `an_n`  out  4  digit anodes, active-low, bit n = digit n.

## Operation
- Reset values: `dig_sel`=0, `disp_value`=16'h0000, `an_n`=4'hF, `seg_n`=7'h7F, `dp_n`=1, `load_ack`=0, prescaler=0, state=BLANK with blank count 0, pending flag clear.
- Prescaler counts 0..TICK_DIV-1 and wraps. A tick occurs on the wrap cycle.
- On each tick, `dig_sel` increments modulo 4 (3→0) and the FSM enters BLANK.
- FSM has two states:
  - BLANK: `an_n`=4'hF. A counter runs BLANK_CYCLES cycles, then the FSM moves to SHOW.
  - SHOW: `an_n` has only bit `dig_sel` low, qualified by `enable` (and by blanking under the macro). The FSM stays in SHOW until the next tick.
- `seg_n`/`dp_n` are registered decodes of `selected_value` and `dp[dig_sel]`, updated every cycle.
- Load handshake:
  - `load`=1 latches `value` into a pending register and sets the pending flag.
  - A later `load` before commit overwrites the pending register (last wins, no ack for the dropped value).
- Commit: on the tick where `dig_sel` wraps 3→0 with pending set, the pending value goes to `disp_value`, the pending flag clears, and `load_ack` pulses in the following cycle.
- Simultaneous `load` and wrap tick: the new `value` is committed directly (bypass), and `load_ack` pulses.
- `rst` mid-frame: all state returns to reset values next cycle, and any pending value is discarded without ack.

## Timing
- Tick at cycle T:
  - `dig_sel` new at T+1.
  - `seg_n` reflects the new digit at T+2.
  - `an_n` low for the new digit from T+1+BLANK_CYCLES to the next tick (inclusive).
- Anode-on time per slot is TICK_DIV−BLANK_CYCLES cycles.
- Frame period is 4·TICK_DIV cycles.
- Worst-case load-to-commit latency is 4·TICK_DIV cycles; ack follows commit by 1 cycle.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digit n (n=3..1) stays dark in SHOW if nibble n and all higher nibbles of `disp_value` are zero.
  - Digit 0 is always shown; `dp` still lights its segment on a shown digit only.
- Undefined: all four digits are always shown.

## Structure
- Shared package `seg7_pkg`:
  - 16-entry hex segment pattern constant (active-low, {g..a}).
  - `ANODES_OFF` = 4'hF, `SEG_OFF` = 7'h7F.
  - FSM state enum {BLANK, SHOW}.
- One sub-module, `hex_to_seg7`: combinational 4-bit → 7-bit active-low decoder using the package table; instantiated once, output registered in this block.

## Test plan
Bench uses TICK_DIV=8, BLANK_CYCLES=2 with a behavioural `group_selector`.
- Reset, `enable`=1 → `an_n`=F, `seg_n`=7F, `dig_sel`=0. After the first tick, `dig_sel`=1 and `an_n`=4'b1101 exactly 3 cycles later.
- `load` `value`=16'h1234 mid-frame → no change until the 3→0 wrap. Then `disp_value`=1234, `load_ack` is a single pulse, and digit 0 shows `seg_n`=7'b0011001 ("4").
- Two loads (16'hAAAA then 16'h00F0) before the wrap → only 00F0 committed, exactly one `load_ack`.
- `load` on the exact wrap-tick cycle with 16'hBEEF → committed that tick, ack next cycle.
- Macro on, `disp_value`=16'h00F0 → digits 3 and 2 never light, digits 1 and 0 do. Macro off → all four light.
- `rst` asserted during SHOW with a load pending → all outputs at reset values next cycle, no `load_ack` ever issued.
